led_fade_sequencer: RTL and testbench
=====================================

# led_fade_sequencer

Sequences the brightness of one LED PWM channel through a timed fade cycle: rise, hold, fall, then idle or loop. Contains its own 1 ms tick prescaler, brightness step timer, fade state machine and 8-bit PWM generator. Sits between top-level control (buttons, a CPU register, or tie-offs) and the LED pin. It replaces the free-running brightness ramp with a startable, stoppable, configurable sequence.

## Interface
Parameters:
- `TICK_DIV`, default 25000: clk cycles per tick (1 ms at 25 MHz); must be ≥ 2.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a fade sequence; sampled every cycle.
- `stop` in 1: abort the sequence; sampled every cycle.
- `step_ms` in 8: ticks per brightness step; 0 is treated as 1.
- `hold_ms` in 16: ticks spent at full brightness.
- `loop` in 1: 1 = repeat rise/hold/fall until `stop`.
- `brightness` out 8: current brightness level.
- `pwm_out` out 1: registered PWM drive to the LED.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when a non-looping sequence completes.

## Operation
- **Reset values.** All outputs are 0, state is IDLE, and all counters are 0.
- **Config latch.** `step_ms`, `hold_ms` and `loop` are latched when `start` is accepted. Input changes while busy have no effect.
- **Start acceptance.** `start` is accepted only in IDLE with `stop` low. `start` while busy is ignored. `stop` wins over a simultaneous `start`.
- **Prescaler.** Counts 0..TICK_DIV-1 and wraps. `tick` is an internal one-cycle pulse when the count equals TICK_DIV-1. The prescaler is cleared on start acceptance and held at 0 in IDLE.
- **Step timer.** Counts ticks from 0 to S-1, where S = max(step_ms,1). When a tick arrives at count S-1, it clears and issues a step. It is cleared on every state entry.
- **States:**
  - IDLE: brightness 0.
    - Accepted start → RISE.
  - RISE: each step increments brightness.
    - The step that makes brightness 255 → HOLD.
  - HOLD: counts ticks, with the hold counter cleared on entry.
    - hold_ms = 0 → FALL on the cycle after entry.
    - Otherwise → FALL on the tick that brings the count to hold_ms.
  - FALL: each step decrements brightness.
    - The step that makes brightness 0 → RISE if the latched loop = 1.
    - Otherwise → IDLE, with `done` = 1 for that one cycle.
- **Stop.** `stop` in any non-IDLE state → IDLE at the next edge. Brightness becomes 0 at that edge. No `done` pulse.
- **Brightness range.** Brightness never wraps: it saturates at 255 in RISE and at 0 in FALL.
- **PWM.** `pwm_cnt` is 8 bits, free-running, and not reset by start or stop. `pwm_out` is registered as (`pwm_cnt` < `brightness`).
  - Brightness 0 gives constant low.
  - Brightness 255 gives 255 high cycles per 256.
- **Async reset mid-sequence.** Immediately forces the reset values; no `done` pulse.

## Timing
- **Start edge.** The start-accept edge is cycle 0. `busy` = 1 and state = RISE from cycle 0.
- **First tick.** The first tick occurs at cycle TICK_DIV.
- **Brightness updates.** Brightness goes to k at the edge of tick k·S after start.
- **RISE to HOLD.** HOLD is entered at tick 255·S.
- **HOLD to FALL.** FALL is entered hold_ms ticks after HOLD entry, or 1 cycle after HOLD entry when hold_ms = 0.
- **FALL duration.** FALL lasts 255·S ticks, counted from FALL entry.
  - The prescaler keeps running across state changes and is not realigned.
- **Completion.** `done` rises and `busy` falls at the same edge. A new `start` is accepted from the next cycle.
- **PWM latency.** A brightness change affects `pwm_out` one cycle after `brightness` updates.

## Test plan
1. **Reset mid-sequence.** With TICK_DIV=4, assert `rst` during RISE at brightness 37 → asynchronously `brightness`=0, `pwm_out`=0, `busy`=0, `done`=0. After release, the sequence does not resume.
2. **Full sequence.** TICK_DIV=4, step_ms=1, hold_ms=2, loop=0, pulse `start` → brightness 255 at cycle 1020, FALL entry at cycle 1028, brightness 0 at cycle 2048, one-cycle `done` with `busy` dropping at that edge.
3. **Zero step.** step_ms=0 → timing identical to step_ms=1. With step_ms=3, brightness=1 at cycle 12.
4. **PWM duty.** Hold the sequencer in HOLD with hold_ms=65535, then measure → 255 high cycles per 256. Separately check brightness 0 → `pwm_out` never high, and brightness 64 mid-rise → 64 of 256 high.
5. **Stop cases.**
   - `stop` during HOLD → IDLE next edge, brightness 0, no `done`.
   - `start`+`stop` in the same cycle from IDLE → stays IDLE.
   - `start` while busy → ignored, with no timing change.
6. **Loop mode.** loop=1, hold_ms=0 → after FALL reaches 0, state returns to RISE with no `done` pulse. Changing `loop`, `step_ms` or `hold_ms` inputs while busy has no effect. `stop` ends the loop.

Source files
------------

// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer: single-channel LED fade engine.
// Tick prescaler, step timer, rise/hold/fall FSM and 8-bit PWM.
module led_fade_sequencer #(
  parameter int TICK_DIV = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  step_ms,
  input  logic [15:0] hold_ms,
  input  logic        loop,
  output logic [7:0]  brightness,
  output logic        pwm_out,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    HOLD,
    FALL
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [7:0]    stcnt;
  logic [7:0]    step_l;
  logic [7:0]    pwm_cnt;
  logic [15:0]   hcnt;
  logic [15:0]   hold_l;
  logic          loop_l;
  logic          tick;
  logic          step;
  logic [7:0]    s_last;

  // a latched step of 0 behaves as 1, so the last count is 0
  assign s_last = (step_l == 8'd0) ? 8'd0
                                   : step_l - 8'd1;
  assign tick = (presc == PMAX);
  assign step = tick && (stcnt == s_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      stcnt      <= '0;
      hcnt       <= '0;
      step_l     <= '0;
      hold_l     <= '0;
      loop_l     <= 1'b0;
      pwm_cnt    <= '0;
      pwm_out    <= 1'b0;
      brightness <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_out <= (pwm_cnt < brightness);
      done    <= 1'b0;

      if (state == IDLE || tick) presc <= '0;
      else presc <= presc + PW'(1);

      if (tick) stcnt <= step ? 8'd0 : stcnt + 8'd1;

      if (state != IDLE && stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        brightness <= '0;
        presc      <= '0;
        stcnt      <= '0;
        hcnt       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            brightness <= '0;
            if (start && !stop) begin
              state  <= RISE;
              busy   <= 1'b1;
              step_l <= step_ms;
              hold_l <= hold_ms;
              loop_l <= loop;
              stcnt  <= '0;
              hcnt   <= '0;
            end
          end
          RISE: begin
            if (step) begin
              if (brightness != 8'hff)
                brightness <= brightness + 8'd1;
              if (brightness == 8'hfe) begin
                state <= HOLD;
                stcnt <= '0;
                hcnt  <= '0;
              end
            end
          end
          HOLD: begin
            if (hold_l == 16'd0) begin
              state <= FALL;
              stcnt <= '0;
            end else if (tick) begin
              if (hcnt + 16'd1 == hold_l) begin
                state <= FALL;
                stcnt <= '0;
              end else begin
                hcnt <= hcnt + 16'd1;
              end
            end
          end
          FALL: begin
            if (step) begin
              if (brightness != 8'd0)
                brightness <= brightness - 8'd1;
              if (brightness == 8'd1) begin
                stcnt <= '0;
                if (loop_l) begin
                  state <= RISE;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb_led_fade_sequencer: vector table, corner sequences and a
// cycle-by-cycle scoreboard against a closed-form fade model.
module tb_led_fade_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  step_ms;
  logic [15:0] hold_ms;
  logic        loop;
  logic [7:0]  brightness;
  logic        pwm_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  led_fade_sequencer #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step_ms    (step_ms),
    .hold_ms    (hold_ms),
    .loop       (loop),
    .brightness (brightness),
    .pwm_out    (pwm_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Brightness m cycles after start, from the tick-count rules:
  // ramp up over 255*S ticks, hold H ticks, ramp down 255*S ticks.
  function automatic int fb(input int m, input int s,
                            input int h, input bit l);
    int j;
    int p;
    j = m / TD;
    p = 510 * s + h;
    if (l) j = j % p;
    if (j <= 255 * s) return j / s;
    if (j < 255 * s + h) return 255;
    return 255 - (j - 255 * s - h) / s;
  endfunction

  logic       m_act;
  int         m_cyc;
  int         m_s;
  int         m_h;
  logic       m_l;
  logic       m_done;
  logic       m_pwm;
  logic [7:0] pcnt;
  int         m_bright;

  always_comb m_bright = m_act ? fb(m_cyc, m_s, m_h, m_l) : 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_cyc  <= 0;
      m_s    <= 1;
      m_h    <= 0;
      m_l    <= 1'b0;
      m_done <= 1'b0;
      m_pwm  <= 1'b0;
      pcnt   <= '0;
    end else begin
      m_pwm  <= (int'(pcnt) < m_bright);
      pcnt   <= pcnt + 8'd1;
      m_done <= 1'b0;
      if (m_act) begin
        if (stop) begin
          m_act <= 1'b0;
        end else if (!m_l &&
                     m_cyc + 1 == (510 * m_s + m_h) * TD) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
        end else begin
          m_cyc <= m_cyc + 1;
        end
      end else if (start && !stop) begin
        m_act <= 1'b1;
        m_cyc <= 0;
        m_s   <= (step_ms == 8'd0) ? 1 : int'(step_ms);
        m_h   <= int'(hold_ms);
        m_l   <= loop;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("sb_bright", int'(brightness), m_bright);
      chk("sb_busy", int'(busy), int'(m_act));
      chk("sb_done", int'(done), int'(m_done));
      chk("sb_pwm", int'(pwm_out), int'(m_pwm));
    end
  end

  typedef struct {
    logic [7:0]  stp;
    logic [15:0] hld;
    logic        lp;
    int          cyc;
    int          eb;
    logic        ebusy;
    logic        edone;
  } vec_t;

  vec_t tbl[13];

  task automatic stop_pulse();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // returns at 1 time unit after the accept edge (cycle 0)
  task automatic start_seq(input logic [7:0] s,
                           input logic [15:0] h,
                           input logic l);
    @(negedge clk);
    step_ms = s;
    hold_ms = h;
    loop    = l;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int cnt;
    rst     = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    step_ms = 8'd1;
    hold_ms = 16'd0;
    loop    = 1'b0;

    tbl[0]  = '{8'd1, 16'd2, 1'b0,    4,   1, 1'b1, 1'b0};
    tbl[1]  = '{8'd3, 16'd2, 1'b0,   11,   0, 1'b1, 1'b0};
    tbl[2]  = '{8'd3, 16'd2, 1'b0,   12,   1, 1'b1, 1'b0};
    tbl[3]  = '{8'd0, 16'd2, 1'b0,    4,   1, 1'b1, 1'b0};
    tbl[4]  = '{8'd0, 16'd2, 1'b0, 1020, 255, 1'b1, 1'b0};
    tbl[5]  = '{8'd1, 16'd2, 1'b0, 1027, 255, 1'b1, 1'b0};
    tbl[6]  = '{8'd1, 16'd2, 1'b0, 1032, 254, 1'b1, 1'b0};
    tbl[7]  = '{8'd1, 16'd2, 1'b0, 2044,   1, 1'b1, 1'b0};
    tbl[8]  = '{8'd1, 16'd2, 1'b0, 2048,   0, 1'b0, 1'b1};
    tbl[9]  = '{8'd1, 16'd0, 1'b1, 2040,   0, 1'b1, 1'b0};
    tbl[10] = '{8'd1, 16'd0, 1'b1, 2044,   1, 1'b1, 1'b0};
    tbl[11] = '{8'd2, 16'd1, 1'b0,    7,   0, 1'b1, 1'b0};
    tbl[12] = '{8'd2, 16'd1, 1'b0,    8,   1, 1'b1, 1'b0};

    #1;
    chk("rst_bright", int'(brightness), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      stop_pulse();
      start_seq(tbl[i].stp, tbl[i].hld, tbl[i].lp);
      repeat (tbl[i].cyc) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_bright", i),
          int'(brightness), tbl[i].eb);
      chk($sformatf("vec%0d_busy", i),
          int'(busy), int'(tbl[i].ebusy));
      chk($sformatf("vec%0d_done", i),
          int'(done), int'(tbl[i].edone));
    end
    stop_pulse();

    // asynchronous reset in RISE at brightness 37
    start_seq(8'd1, 16'd2, 1'b0);
    repeat (148) @(posedge clk);
    #1 chk("pre_rst_bright", int'(brightness), 37);
    #1 rst = 1'b1;
    #1;
    chk("arst_bright", int'(brightness), 0);
    chk("arst_pwm", int'(pwm_out), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_bright", int'(brightness), 0);

    // start and stop together from IDLE
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    repeat (5) @(posedge clk);
    #1 chk("ss_busy_later", int'(busy), 0);

    // start while busy changes nothing
    start_seq(8'd1, 16'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    start   = 1'b1;
    step_ms = 8'd7;
    hold_ms = 16'd5;
    loop    = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("rebusy_bright", int'(brightness), 5);
    stop_pulse();

    // stop during HOLD
    start_seq(8'd1, 16'd100, 1'b0);
    repeat (1030) @(posedge clk);
    #1 chk("hold_bright", int'(brightness), 255);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    chk("hstop_busy", int'(busy), 0);
    chk("hstop_bright", int'(brightness), 0);
    chk("hstop_done", int'(done), 0);

    // PWM duty at 255, 0 and 64
    start_seq(8'd1, 16'hffff, 1'b0);
    repeat (1024) @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1 cnt += int'(pwm_out);
    end
    chk("duty255", cnt, 255);
    stop_pulse();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1 cnt += int'(pwm_out);
    end
    chk("duty0", cnt, 0);
    start_seq(8'd64, 16'd0, 1'b0);
    repeat (16384) @(posedge clk);
    #1 chk("b64_bright", int'(brightness), 64);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1 cnt += int'(pwm_out);
    end
    chk("duty64", cnt, 64);
    stop_pulse();

    // loop mode, inputs changed while busy, stop ends it
    start_seq(8'd1, 16'd0, 1'b1);
    cnt = 0;
    for (int c = 0; c < 2044; c++) begin
      @(posedge clk);
      #1 cnt += int'(done);
      if (c == 4) begin
        step_ms = 8'd9;
        hold_ms = 16'd3;
        loop    = 1'b0;
      end
    end
    chk("loop_bright", int'(brightness), 1);
    chk("loop_busy", int'(busy), 1);
    chk("loop_dones", cnt, 0);
    stop_pulse();
    #1 chk("loop_stopped", int'(busy), 0);

    // randomized traffic against the scoreboard
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 2999) == 0);
      step_ms = 8'($urandom_range(0, 2));
      hold_ms = 16'($urandom_range(0, 6));
      loop    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
